fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the FIFO between NREQ requesters using round-robin arbitration with bounded bursts.
- Sits in the w_clk domain, directly in front of the FIFO's w_data/w_en inputs.
- Consumes the FIFO's full and almost_full flags and only asserts a write when the FIFO can accept it.
- Returns a per-beat acknowledge to the requester that owns the port.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- DW, 8, data width per requester and of the FIFO write data.
- BURST, 4, maximum beats per grant before re-arbitration; legal value >= 1.

Ports:
- clk  input  1  write-domain clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester write request; bit i belongs to requester i.
- data  input  NREQ*DW  flattened requester data; requester i uses bits [i*DW +: DW].
- ack  output  NREQ  one-hot, combinational; bit i high means requester i's beat is written this cycle.
- grant  output  NREQ  registered, one-hot or zero; shows the current burst owner.
- busy  output  1  high while the block is in state BURST.
- fifo_w_data  output  DW  write data to the FIFO.
- fifo_w_en  output  1  write enable to the FIFO.
- fifo_full  input  1  FIFO full flag.
- fifo_almost_full  input  1  FIFO almost-full flag.

Behaviour:
- State machine has two states: IDLE and BURST.
- Internal registers:
  - state
  - grant
  - owner index, clog2(NREQ) bits
  - last_winner, clog2(NREQ) bits
  - beat_cnt, max(1, clog2(BURST)) bits
- Reset, on a clk edge with rst high:
  - state=IDLE, grant=0, beat_cnt=0, last_winner=NREQ-1, so requester 0 has priority first.
  - While rst is high, fifo_w_en=0 and ack=0 combinationally, regardless of state.
- IDLE:
  - If req is nonzero, pick the first set req bit searching upward from last_winner+1, wrapping modulo NREQ.
  - Next edge: grant is that one-hot value, owner = that index, beat_cnt=0, state=BURST.
  - No write is ever issued while in IDLE.
- BURST, with owner i:
  - A beat occurs when req[i] & ~fifo_full.
  - On a beat: fifo_w_en=1, ack[i]=1, fifo_w_data=data[i], and beat_cnt increments.
  - Stall: if req[i] & fifo_full, there is no write and no ack; grant, beat_cnt and state all hold.
  - The burst terminates (next state IDLE, grant=0, last_winner=i) when any of these holds:
    - a beat occurs and beat_cnt==BURST-1;
    - a beat occurs and fifo_almost_full=1;
    - req[i]=0, with or without fifo_full.
- Outputs outside a beat:
  - fifo_w_en=0 and ack=0.
  - fifo_w_data = data[owner] in BURST; all zeros in IDLE.
- ack is at most one-hot and always equals grant & {NREQ{fifo_w_en}}.
- Requests from non-owners are ignored until re-arbitration. Requesters hold their data stable until they see ack.
- Re-arbitration always costs exactly one IDLE cycle. Peak throughput is BURST beats per BURST+1 cycles.
- Simultaneous events: requests that assert in the same cycle as a release are considered in the following IDLE cycle.
- Reset mid-burst: the burst is abandoned and no partial-state carry-over is allowed. After reset the block is in IDLE with last_winner=NREQ-1.
- A write is never issued while fifo_full=1; the FIFO's own full gating remains a backstop only.

Test Plan:
- Reset with all requests active:
  - Stimulus: rst=1 for 2 cycles with req=4'b1111.
  - Required: fifo_w_en=0, ack=0, grant=0 throughout reset.
  - After release: grant=4'b0001 one cycle after the first IDLE cycle.
- Single-requester burst:
  - Stimulus: req=4'b0010 held, data[1] = 0x10, 0x11, 0x12, 0x13 advanced on each ack.
  - Required: 4 consecutive beats writing 0x10..0x13, then 1 IDLE cycle, then grant=4'b0010 again.
- Round-robin order:
  - Stimulus: all req held, FIFO never full.
  - Required: grant order 0,1,2,3,0 with 4 beats each; exactly 16 writes in 20 cycles.
- Full stall:
  - Stimulus: fifo_full high for 3 cycles after beat 2.
  - Required: no w_en or ack during the stall; grant and busy stay high; beats 3 and 4 follow once full drops; exactly 4 beats total.
- Early release:
  - Stimulus: req[2] drops after 2 beats while req[3] is pending.
  - Required: IDLE on the next cycle, then grant=4'b1000; req[0] does not win first.
- Almost-full cut and reset mid-burst:
  - Almost-full: assert fifo_almost_full with beat 1 → that beat is written and the burst ends (1 beat).
  - Reset mid-burst: rst=1 during BURST → w_en=0 immediately; grant=0 after the edge; the next grant restarts from requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a FIFO.
// Each grant gives one requester a burst of at most BURST beats. A new
// grant is always issued from IDLE, so the FIFO sees BURST writes per
// BURST+1 cycles at best. Writes are held off while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic [DW-1:0]      fifo_w_data,
  output logic               fifo_w_en,
  input  logic               fifo_full,
  input  logic               fifo_almost_full
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q,  last_d;
  logic [BW-1:0]   cnt_q,   cnt_d;

  logic [DW-1:0]   data_arr [NREQ];
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic            beat_c;

  // Unflatten requester data so the owner can select its lane directly.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_arr[g] = data[g*DW +: DW];
  end

  // Round-robin search starting just above the previous winner.
  always_comb begin
    int unsigned cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last_q) + k) % NREQ;
      if (!win_found && req[IW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  // Beat qualification and FIFO-facing outputs; reset masks any write.
  always_comb begin
    beat_c      = (state_q == ST_BURST) && req[owner_q] && !fifo_full && !rst;
    fifo_w_en   = beat_c;
    ack         = grant_q & {NREQ{beat_c}};
    fifo_w_data = (state_q == ST_BURST) ? data_arr[owner_q] : '0;
  end

  assign grant = grant_q;
  assign busy  = (state_q == ST_BURST);

  // Next-state logic: grant from IDLE, count beats and release in BURST.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_BURST;
          grant_d = NREQ'(1) << win_idx;
          owner_d = win_idx;
          cnt_d   = '0;
        end
      end
      ST_BURST: begin
        if (!req[owner_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_q;
          cnt_d   = '0;
        end else if (!fifo_full) begin
          if ((cnt_q == BW'(BURST - 1)) || fifo_almost_full) begin
            state_d = ST_IDLE;
            grant_d = '0;
            last_d  = owner_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset; requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: cycle vector table with a write-data
// scoreboard, followed by a randomized run checking port invariants.
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        full;
    logic        af;
    logic [31:0] dat;
    logic [3:0]  ack;
    logic        en;
    logic [3:0]  grant;
    logic        busy;
    logic [7:0]  wd;
  } vec_t;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [DW-1:0]     fifo_w_data;
  logic              fifo_w_en;
  logic              fifo_full;
  logic              fifo_almost_full;

  vec_t        vecs[$];
  logic [7:0]  exp_q[$];
  int          n_vec;
  int          n_bad;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .data             (data),
    .ack              (ack),
    .grant            (grant),
    .busy             (busy),
    .fifo_w_data      (fifo_w_data),
    .fifo_w_en        (fifo_w_en),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic void v(input logic r, input logic [3:0] rq, input logic f,
                            input logic af, input logic [31:0] d, input logic [3:0] a,
                            input logic en, input logic [3:0] g, input logic b,
                            input logic [7:0] wd);
    vec_t t;
    t.rst = r; t.req = rq; t.full = f; t.af = af; t.dat = d;
    t.ack = a; t.en = en; t.grant = g; t.busy = b; t.wd = wd;
    vecs.push_back(t);
  endfunction

  localparam logic [31:0] D = 32'hA3A2_A1A0;

  initial begin
    logic [7:0] got;
    logic [7:0] lane [4];
    int         gi;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1; req = 4'hF; data = D; fifo_full = 1'b0; fifo_almost_full = 1'b0;

    // Reset with all requests active, then release.
    v(1, 4'hF, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);
    v(1, 4'hF, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);
    v(0, 4'hF, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);
    // Round robin 0,1,2,3,0 with one IDLE between bursts.
    for (int r = 0; r < 5; r++) begin
      logic [3:0] g;
      logic [7:0] w;
      g = 4'(1) << (r % 4);
      w = 8'hA0 + 8'(r % 4);
      for (int b = 0; b < 4; b++) v(0, 4'hF, 0, 0, D, g, 1, g, 1, w);
      if (r < 4) v(0, 4'hF, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);
    end
    v(0, 4'h0, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);
    // Single requester 1 with advancing data.
    v(0, 4'h2, 0, 0, 32'hA3A2_10A0, 4'h0, 0, 4'h0, 0, 8'h00);
    v(0, 4'h2, 0, 0, 32'hA3A2_10A0, 4'h2, 1, 4'h2, 1, 8'h10);
    v(0, 4'h2, 0, 0, 32'hA3A2_11A0, 4'h2, 1, 4'h2, 1, 8'h11);
    v(0, 4'h2, 0, 0, 32'hA3A2_12A0, 4'h2, 1, 4'h2, 1, 8'h12);
    v(0, 4'h2, 0, 0, 32'hA3A2_13A0, 4'h2, 1, 4'h2, 1, 8'h13);
    v(0, 4'h2, 0, 0, 32'hA3A2_14A0, 4'h0, 0, 4'h0, 0, 8'h00);
    v(0, 4'h2, 0, 0, 32'hA3A2_14A0, 4'h2, 1, 4'h2, 1, 8'h14);
    v(0, 4'h0, 0, 0, 32'hA3A2_15A0, 4'h0, 0, 4'h2, 1, 8'h15);
    v(0, 4'h0, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);
    // Full stall after beat 2.
    v(0, 4'h1, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);
    v(0, 4'h1, 0, 0, D, 4'h1, 1, 4'h1, 1, 8'hA0);
    v(0, 4'h1, 0, 0, D, 4'h1, 1, 4'h1, 1, 8'hA0);
    for (int s = 0; s < 3; s++) v(0, 4'h1, 1, 0, D, 4'h0, 0, 4'h1, 1, 8'hA0);
    v(0, 4'h1, 0, 0, D, 4'h1, 1, 4'h1, 1, 8'hA0);
    v(0, 4'h1, 0, 0, D, 4'h1, 1, 4'h1, 1, 8'hA0);
    v(0, 4'h0, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);
    // Early release by requester 2; requester 3 wins before 0.
    v(0, 4'h4, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);
    v(0, 4'hD, 0, 0, D, 4'h4, 1, 4'h4, 1, 8'hA2);
    v(0, 4'hD, 0, 0, D, 4'h4, 1, 4'h4, 1, 8'hA2);
    v(0, 4'h9, 0, 0, D, 4'h0, 0, 4'h4, 1, 8'hA2);
    v(0, 4'h9, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);
    v(0, 4'h9, 0, 0, D, 4'h8, 1, 4'h8, 1, 8'hA3);
    v(0, 4'h1, 0, 0, D, 4'h0, 0, 4'h8, 1, 8'hA3);
    v(0, 4'h0, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);
    // Almost-full ends the burst after the qualifying beat.
    v(0, 4'h1, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);
    v(0, 4'h1, 0, 1, D, 4'h1, 1, 4'h1, 1, 8'hA0);
    v(0, 4'h0, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);
    // Reset mid-burst; arbitration restarts at requester 0.
    v(0, 4'h4, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);
    v(0, 4'h4, 0, 0, D, 4'h4, 1, 4'h4, 1, 8'hA2);
    v(1, 4'h4, 0, 0, D, 4'h0, 0, 4'h4, 1, 8'hA2);
    v(0, 4'hF, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);
    v(0, 4'hF, 0, 0, D, 4'h1, 1, 4'h1, 1, 8'hA0);
    v(0, 4'h0, 0, 0, D, 4'h0, 0, 4'h1, 1, 8'hA0);
    v(0, 4'h0, 0, 0, D, 4'h0, 0, 4'h0, 0, 8'h00);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; req = vecs[i].req; fifo_full = vecs[i].full;
      fifo_almost_full = vecs[i].af; data = vecs[i].dat;
      if (vecs[i].en) exp_q.push_back(vecs[i].wd);
      #1;
      chk("ack",   i, 32'(ack),   32'(vecs[i].ack));
      chk("w_en",  i, 32'(fifo_w_en), 32'(vecs[i].en));
      chk("grant", i, 32'(grant), 32'(vecs[i].grant));
      chk("busy",  i, 32'(busy),  32'(vecs[i].busy));
      chk("w_data", i, 32'(fifo_w_data), 32'(vecs[i].wd));
      if (fifo_w_en) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_write", i, 32'(fifo_w_data), 32'hFFFF_FFFF);
        end else begin
          got = exp_q.pop_front();
          chk("sb_write", i, 32'(fifo_w_data), 32'(got));
        end
      end
    end
    chk("sb_empty", 0, 32'(exp_q.size()), 32'd0);

    // Randomized traffic: port invariants every cycle.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst = 1'b0;
      req = 4'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      fifo_almost_full = ($urandom_range(0, 7) == 0);
      data = $urandom;
      #1;
      for (int k = 0; k < 4; k++) lane[k] = data[k*8 +: 8];
      chk("never_write_full", c, 32'(fifo_w_en & fifo_full), 32'd0);
      chk("ack_eq_grant_en", c, 32'(ack), 32'(grant & {4{fifo_w_en}}));
      chk("grant_onehot0", c, 32'($onehot0(grant)), 32'd1);
      if (fifo_w_en) begin
        gi = 0;
        for (int k = 0; k < 4; k++) if (grant[k]) gi = k;
        chk("rand_w_data", c, 32'(fifo_w_data), 32'(lane[gi]));
      end
    end

    @(negedge clk);
    req = '0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
